frame_sequencer: RTL and testbench

Per-frame scheduler for the vertex-transform datapath. On each frame tick it snapshots the camera pose (theta, x, y, z) produced by the pose/keyboard unit. It then issues one transform request per model vertex through a valid/ready handshake and waits for each result. Once all vertices are done, it kicks the rasterizer and swaps the double-buffer select, counting frame ticks it had to drop because the previous frame was still in flight.

---
 rtl/gfx_pkg.sv | 27 ++
 rtl/frame_sequencer.sv | 146 ++++++++++++++
 tb/tb_frame_sequencer.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/gfx_pkg.sv
// ---------------------------------------------------------------------------
// gfx_pkg
//   Shared types and constants for the graphics pipeline control blocks.
//   fs_state_t : frame_sequencer FSM states (also exported for debug)
//   pose_t     : camera pose record (theta 4.8 fixed point, x/y/z 8.8)
//   DROP_CNT_W : width of the saturating dropped-tick counter
// ---------------------------------------------------------------------------
package gfx_pkg;

   localparam int DROP_CNT_W = 8;
   localparam int POSE_W     = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      KICK  = 2'd3
   } fs_state_t;

   typedef struct packed {
      logic [11:0]       theta;
      logic [POSE_W-1:0] x;
      logic [POSE_W-1:0] y;
      logic [POSE_W-1:0] z;
   } pose_t;

endpackage

// File: rtl/frame_sequencer.sv
// ---------------------------------------------------------------------------
// frame_sequencer
//   Per-frame scheduler for the vertex-transform datapath. A frame tick in
//   IDLE snapshots the camera pose, then one transform request per vertex is
//   issued and its result awaited. After the last vertex the rasterizer is
//   kicked and the double-buffer select flips. Ticks arriving while a frame
//   is still in flight are dropped and counted.
//
// Ports
//   Clk, Reset              clock, synchronous active-high reset
//   frame_clk_rising_edge   one-cycle frame tick
//   theta, x, y, z          live camera pose
//   xf_req_valid/ready      transform request handshake
//   xf_vidx, xf_theta..z    request payload (vertex index + latched pose)
//   xf_rsp_valid            one-cycle pulse: accepted request finished
//   raster_start/done       rasterizer kick / completion pulses
//   buf_sel                 vertex-buffer half currently being written
//   busy                    frame in flight (state != IDLE)
//   frame_drop, drop_cnt    dropped-tick pulse and saturating count
//   state_dbg               current FSM state
//
// Handshake: a request transfers on any cycle where xf_req_valid and
// xf_req_ready are both high. Once valid is raised it stays high, and
// xf_vidx and xf_theta/x/y/z stay unchanged, until that transfer happens.
// Only one request is ever outstanding; the next is issued only after
// xf_rsp_valid for the previous one.
// ---------------------------------------------------------------------------
module frame_sequencer
   import gfx_pkg::*;
#(
   parameter int WI = 8,
   parameter int WF = 8,
   parameter int NV = 8,
   parameter int AW = $clog2(NV)
) (
   input  logic                  Clk,
   input  logic                  Reset,
   input  logic                  frame_clk_rising_edge,
   input  logic [11:0]           theta,
   input  logic [WI+WF-1:0]      x,
   input  logic [WI+WF-1:0]      y,
   input  logic [WI+WF-1:0]      z,
   output logic                  xf_req_valid,
   input  logic                  xf_req_ready,
   output logic [AW-1:0]         xf_vidx,
   output logic [11:0]           xf_theta,
   output logic [WI+WF-1:0]      xf_x,
   output logic [WI+WF-1:0]      xf_y,
   output logic [WI+WF-1:0]      xf_z,
   input  logic                  xf_rsp_valid,
   output logic                  raster_start,
   input  logic                  raster_done,
   output logic                  buf_sel,
   output logic                  busy,
   output logic                  frame_drop,
   output logic [DROP_CNT_W-1:0] drop_cnt,
   output fs_state_t             state_dbg
);

   localparam logic [AW-1:0] LAST_IDX = AW'(NV - 1);

   fs_state_t     state, state_n;
   logic [AW-1:0] idx, idx_n;
   logic          raster_busy;
   logic          tick_accept;
   logic          tick_drop;

   assign tick_accept = frame_clk_rising_edge && (state == IDLE);
   assign tick_drop   = frame_clk_rising_edge && (state != IDLE);

   // Decoded from registered state only; raster_start fires in the first
   // KICK cycle in which the previous raster pass has been released.
   assign xf_req_valid = (state == ISSUE);
   assign raster_start = (state == KICK) && !raster_busy;
   assign busy         = (state != IDLE);
   assign xf_vidx      = idx;
   assign state_dbg    = state;

   always_comb begin
      state_n = state;
      idx_n   = idx;
      case (state)
         IDLE: begin
            if (frame_clk_rising_edge) begin
               state_n = ISSUE;
               idx_n   = '0;
            end
         end
         ISSUE: begin
            if (xf_req_ready) state_n = WAIT;
         end
         WAIT: begin
            if (xf_rsp_valid) begin
               if (idx == LAST_IDX) begin
                  state_n = KICK;
               end else begin
                  state_n = ISSUE;
                  idx_n   = idx + 1'b1;
               end
            end
         end
         KICK: begin
            if (!raster_busy) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state       <= IDLE;
         idx         <= '0;
         xf_theta    <= '0;
         xf_x        <= '0;
         xf_y        <= '0;
         xf_z        <= '0;
         buf_sel     <= 1'b0;
         raster_busy <= 1'b0;
         frame_drop  <= 1'b0;
         drop_cnt    <= '0;
      end else begin
         state <= state_n;
         idx   <= idx_n;

         // Pose is captured only on an accepted tick so the whole frame
         // is transformed with one consistent camera.
         if (tick_accept) begin
            xf_theta <= theta;
            xf_x     <= x;
            xf_y     <= y;
            xf_z     <= z;
         end

         if (raster_start) buf_sel <= ~buf_sel;

         // raster_start only fires while not busy, so set and clear never
         // collide; a stray raster_done while idle leaves the flag at 0.
         if (raster_start)     raster_busy <= 1'b1;
         else if (raster_done) raster_busy <= 1'b0;

         frame_drop <= tick_drop;
         if (tick_drop && (drop_cnt != '1)) drop_cnt <= drop_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_frame_sequencer.sv
module tb_frame_sequencer;
   import gfx_pkg::*;

   localparam int WI = 8;
   localparam int WF = 8;
   localparam int NV = 8;
   localparam int AW = 3;
   localparam int PW = WI + WF;

   localparam logic [11:0]   TH0 = 12'h0C8;
   localparam logic [PW-1:0] X0  = 16'h0100;
   localparam logic [PW-1:0] Y0  = 16'h0280;
   localparam logic [PW-1:0] Z0  = 16'hFF40;
   localparam logic [11:0]   TH1 = 12'h3A5;
   localparam logic [PW-1:0] X1  = 16'h1234;
   localparam logic [PW-1:0] Y1  = 16'hFEDC;
   localparam logic [PW-1:0] Z1  = 16'h0F0F;
   localparam logic [11:0]   TH2 = 12'hB17;
   localparam logic [PW-1:0] X2  = 16'h7E01;
   localparam logic [PW-1:0] Y2  = 16'h0042;
   localparam logic [PW-1:0] Z2  = 16'hA5A5;

   // ---------------- clock / reset ----------------
   logic Clk = 1'b0;
   logic Reset = 1'b1;
   initial forever #5 Clk = ~Clk;

   logic            frame_clk_rising_edge = 1'b0;
   logic [11:0]     theta = '0;
   logic [PW-1:0]   x = '0;
   logic [PW-1:0]   y = '0;
   logic [PW-1:0]   z = '0;
   logic            xf_req_ready = 1'b1;
   logic            xf_rsp_valid = 1'b0;
   logic            raster_done = 1'b0;
   logic            xf_req_valid;
   logic [AW-1:0]   xf_vidx;
   logic [11:0]     xf_theta;
   logic [PW-1:0]   xf_x, xf_y, xf_z;
   logic            raster_start;
   logic            buf_sel;
   logic            busy;
   logic            frame_drop;
   logic [7:0]      drop_cnt;
   fs_state_t       state_dbg;

   frame_sequencer #(.WI(WI), .WF(WF), .NV(NV), .AW(AW)) dut (
      .Clk(Clk), .Reset(Reset),
      .frame_clk_rising_edge(frame_clk_rising_edge),
      .theta(theta), .x(x), .y(y), .z(z),
      .xf_req_valid(xf_req_valid), .xf_req_ready(xf_req_ready),
      .xf_vidx(xf_vidx), .xf_theta(xf_theta),
      .xf_x(xf_x), .xf_y(xf_y), .xf_z(xf_z),
      .xf_rsp_valid(xf_rsp_valid),
      .raster_start(raster_start), .raster_done(raster_done),
      .buf_sel(buf_sel), .busy(busy),
      .frame_drop(frame_drop), .drop_cnt(drop_cnt),
      .state_dbg(state_dbg)
   );

   // ---------------- scoreboard ----------------
   int n_cmp = 0;
   int n_err = 0;
   logic [AW-1:0] exp_q[$];
   bit rsp_en = 1'b1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Transform-unit model: every accepted request is matched against the
   // next expected vertex index and answered with a pulse the next cycle.
   initial begin
      bit acc;
      forever begin
         @(negedge Clk);
         #1;
         acc = xf_req_valid && xf_req_ready && !Reset;
         if (acc) begin
            if (exp_q.size() == 0) check("sb_unexpected_accept", 32'(xf_vidx), 32'hFFFF_FFFF);
            else check("sb_vidx", 32'(xf_vidx), 32'(exp_q.pop_front()));
         end
         @(posedge Clk);
         #1;
         xf_rsp_valid = acc && rsp_en;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic set_pose(input logic [11:0] th, input logic [PW-1:0] xv, yv, zv);
      theta = th; x = xv; y = yv; z = zv;
   endtask

   task automatic check_pose(input string tag, input logic [11:0] th, input logic [PW-1:0] xv, yv, zv);
      check({tag, "_theta"}, 32'(xf_theta), 32'(th));
      check({tag, "_x"}, 32'(xf_x), 32'(xv));
      check({tag, "_y"}, 32'(xf_y), 32'(yv));
      check({tag, "_z"}, 32'(xf_z), 32'(zv));
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_state"}, 32'(state_dbg), 32'(IDLE));
      check({tag, "_valid"}, 32'(xf_req_valid), 0);
      check({tag, "_vidx"}, 32'(xf_vidx), 0);
      check({tag, "_rstart"}, 32'(raster_start), 0);
      check({tag, "_bufsel"}, 32'(buf_sel), 0);
      check({tag, "_busy"}, 32'(busy), 0);
      check({tag, "_drop"}, 32'(frame_drop), 0);
      check({tag, "_dropcnt"}, 32'(drop_cnt), 0);
      check_pose(tag, '0, '0, '0, '0);
   endtask

   task automatic pulse_done();
      raster_done = 1'b1;
      @(negedge Clk);
      raster_done = 1'b0;
   endtask

   // Issues a tick at cycle 0 (called at a negedge) and follows the frame.
   // Returns at the negedge one cycle after raster_start, or after max_c
   // cycles with start_c = -1.
   task automatic run_frame(input int max_c, input int stall_v, input int stall_n,
                            input bit chg, input bit drops,
                            output int start_c, output int drop_seen);
      int t;
      int stalled;
      bit done;
      start_c = -1; drop_seen = 0; stalled = 0; t = 0; done = 1'b0;
      for (int v = 0; v < NV; v++) exp_q.push_back(AW'(v));
      frame_clk_rising_edge = 1'b1;
      xf_req_ready = 1'b1;
      while (!done) begin
         @(negedge Clk);
         t++;
         frame_clk_rising_edge = 1'b0;
         if (t == 1) check("valid_rise_c1", 32'(xf_req_valid), 1);
         if (frame_drop) drop_seen++;
         if (start_c < 0 && raster_start) start_c = t;
         if (stalled > 0 && stalled <= stall_n) begin
            check("stall_valid", 32'(xf_req_valid), 1);
            check("stall_vidx", 32'(xf_vidx), 32'(stall_v));
         end
         if (stalled == 0 && stall_n > 0 && xf_req_valid && int'(xf_vidx) == stall_v) begin
            xf_req_ready = 1'b0; stalled = 1;
         end else if (stalled > 0 && stalled < stall_n) begin
            xf_req_ready = 1'b0; stalled++;
         end else begin
            xf_req_ready = 1'b1;
            if (stall_n > 0 && stalled == stall_n) stalled++;
         end
         if (chg && t == 5) set_pose(TH2, X2, Y2, Z2);
         if (drops && (t == 4 || t == 6 || t == 8)) frame_clk_rising_edge = 1'b1;
         if (start_c >= 0 && t > start_c) done = 1'b1;
         if (t >= max_c) done = 1'b1;
      end
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int sc, ds;
      bit found;

      repeat (3) @(negedge Clk);
      check_reset_outputs("rst0");
      Reset = 1'b0;
      @(negedge Clk);

      // Frame 1: minimum latency
      set_pose(TH0, X0, Y0, Z0);
      run_frame(40, -1, 0, 1'b0, 1'b0, sc, ds);
      check("f1_start_cycle", 32'(sc), 17);
      check("f1_bufsel", 32'(buf_sel), 1);
      check("f1_busy_c18", 32'(busy), 0);
      check("f1_start_pulse", 32'(raster_start), 0);
      check("f1_sb_empty", 32'(exp_q.size()), 0);
      check_pose("f1", TH0, X0, Y0, Z0);
      pulse_done();

      // Frame 2: 5-cycle stall at vertex 3, pose changes mid-frame
      set_pose(TH1, X1, Y1, Z1);
      run_frame(50, 3, 5, 1'b1, 1'b0, sc, ds);
      check("f2_start_cycle", 32'(sc), 22);
      check("f2_bufsel", 32'(buf_sel), 0);
      check("f2_sb_empty", 32'(exp_q.size()), 0);
      check_pose("f2_hold", TH1, X1, Y1, Z1);
      pulse_done();

      // Frame 3: new pose picked up; three ticks dropped mid-frame
      run_frame(40, -1, 0, 1'b0, 1'b1, sc, ds);
      check("f3_start_cycle", 32'(sc), 17);
      check("f3_drop_pulses", 32'(ds), 3);
      check("f3_drop_cnt", 32'(drop_cnt), 3);
      check("f3_bufsel", 32'(buf_sel), 1);
      check_pose("f3_new", TH2, X2, Y2, Z2);

      // Frame 4: raster_done withheld, stuck in KICK
      run_frame(25, -1, 0, 1'b0, 1'b0, sc, ds);
      check("f4_no_start", 32'(sc), 32'hFFFF_FFFF);
      check("f4_state_kick", 32'(state_dbg), 32'(KICK));
      check("f4_busy", 32'(busy), 1);
      check("f4_sb_empty", 32'(exp_q.size()), 0);
      for (int i = 0; i < 257; i++) begin
         frame_clk_rising_edge = 1'b1;
         @(negedge Clk);
      end
      frame_clk_rising_edge = 1'b0;
      @(negedge Clk);
      check("f4_drop_sat", 32'(drop_cnt), 255);
      check("f4_still_kick", 32'(state_dbg), 32'(KICK));
      check("f4_bufsel_held", 32'(buf_sel), 1);
      raster_done = 1'b1;
      check("f4_no_start_at_done", 32'(raster_start), 0);
      @(negedge Clk);
      raster_done = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 3 && !found; i++) begin
         if (raster_start) found = 1'b1;
         else @(negedge Clk);
      end
      check("f4_start_after_done", 32'(found), 1);
      @(negedge Clk);
      check("f4_bufsel", 32'(buf_sel), 0);
      check("f4_busy", 32'(busy), 0);
      pulse_done();

      // Frame 5: reset while waiting on vertex 5
      for (int v = 0; v < NV; v++) exp_q.push_back(AW'(v));
      frame_clk_rising_edge = 1'b1;
      @(negedge Clk);
      frame_clk_rising_edge = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 30 && !found; i++) begin
         if (xf_req_valid && xf_vidx == 3'd5) found = 1'b1;
         else @(negedge Clk);
      end
      check("f5_reach_v5", 32'(found), 1);
      rsp_en = 1'b0;
      @(negedge Clk);
      check("f5_wait_state", 32'(state_dbg), 32'(WAIT));
      check("f5_wait_vidx", 32'(xf_vidx), 5);
      Reset = 1'b1;
      @(negedge Clk);
      check_reset_outputs("rst1");
      Reset = 1'b0;
      rsp_en = 1'b1;
      exp_q.delete();
      @(negedge Clk);
      check("rst1_no_start", 32'(raster_start), 0);

      // Frame 6: fresh start from vertex 0
      run_frame(40, -1, 0, 1'b0, 1'b0, sc, ds);
      check("f6_start_cycle", 32'(sc), 17);
      check("f6_bufsel", 32'(buf_sel), 1);
      check("f6_sb_empty", 32'(exp_q.size()), 0);
      check_pose("f6", TH2, X2, Y2, Z2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
